time_calculate: RTL and testbench

- Parking-duration calculator for the smart parking system: takes a car's entry timestamp and exit timestamp (8-bit time ticks) and produces the elapsed parking time.
- Sits between the gate/timestamp logic and the billing/display stage.
- Registered, single-cycle-latency datapath with a valid strobe, a rollover flag and a running occupancy statistic.

---
 rtl/time_calculate_if.sv | 25 ++
 rtl/time_calculate.sv | 53 +++++
 tb/tb_time_calculate.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/time_calculate_if.sv
// Timestamp-pair request and elapsed-time result bundle for the parking-duration calculator.
// master drives the pair, slave (time_calculate) returns the result and statistics.
interface time_calculate_if #(
  parameter int WIDTH     = 8,
  parameter int SUM_WIDTH = 16
);
  logic                 in_valid;
  logic [WIDTH-1:0]     time_in;
  logic [WIDTH-1:0]     time_out;
  logic [WIDTH-1:0]     time_total;
  logic                 out_valid;
  logic                 wrapped;
  logic [SUM_WIDTH-1:0] total_sum;
  logic [7:0]           car_count;

  modport master (
    output in_valid, time_in, time_out,
    input  time_total, out_valid, wrapped, total_sum, car_count
  );

  modport slave (
    input  in_valid, time_in, time_out,
    output time_total, out_valid, wrapped, total_sum, car_count
  );
endinterface

// File: rtl/time_calculate.sv
// Parking-duration calculator: registered (exit - entry) mod 2^WIDTH with rollover flag and stats.
// Define TIME_CALC_SATURATE_EN to reject rollover pairs (result 0, statistics untouched).
module time_calculate #(
  parameter int WIDTH     = 8,
  parameter int SUM_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  time_calculate_if.slave   bus
);

  logic                 is_wrap;
  logic [WIDTH-1:0]     diff;
  logic [WIDTH-1:0]     result;
  logic                 stats_en;
  logic [SUM_WIDTH:0]   sum_ext;

  always_comb begin
    is_wrap = bus.time_out < bus.time_in;
    diff    = bus.time_out - bus.time_in;
`ifdef TIME_CALC_SATURATE_EN
    result   = is_wrap ? '0 : diff;
    stats_en = !is_wrap;
`else
    result   = diff;
    stats_en = 1'b1;
`endif
    // one extra bit catches the carry so the sum can clamp instead of wrapping
    sum_ext = {1'b0, bus.total_sum} + {{(SUM_WIDTH + 1 - WIDTH){1'b0}}, result};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.time_total <= '0;
      bus.out_valid  <= 1'b0;
      bus.wrapped    <= 1'b0;
      bus.total_sum  <= '0;
      bus.car_count  <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.time_total <= result;
        bus.wrapped    <= is_wrap;
        if (stats_en) begin
          bus.total_sum <= sum_ext[SUM_WIDTH] ? '1 : sum_ext[SUM_WIDTH-1:0];
          if (bus.car_count != 8'hFF)
            bus.car_count <= bus.car_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_time_calculate.sv
// Directed bench for time_calculate: reference model pushes expected results to a queue,
// which are popped and compared one cycle later when out_valid rises.
module tb_time_calculate;

  typedef struct {
    int total;
    int wrap;
    int sum;
    int count;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  time_calculate_if #(.WIDTH(8), .SUM_WIDTH(16)) bus ();

  time_calculate #(.WIDTH(8), .SUM_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // reference model state
  int m_total = 0;
  int m_wrap  = 0;
  int m_sum   = 0;
  int m_count = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step(input bit v, input bit r, input int a, input int b);
    exp_t e;
    int   exp_valid;
    int   t;
    int   w;
    bit   upd;
    bus.in_valid = v;
    bus.time_in  = a[7:0];
    bus.time_out = b[7:0];
    rst          = r;
    exp_valid    = 0;
    if (r) begin
      m_total = 0; m_wrap = 0; m_sum = 0; m_count = 0;
      sb.delete();
    end else if (v) begin
      t   = (b + 256 - a) % 256;
      w   = (b < a) ? 1 : 0;
      upd = 1'b1;
`ifdef TIME_CALC_SATURATE_EN
      if (w == 1) begin
        t   = 0;
        upd = 1'b0;
      end
`endif
      m_total = t;
      m_wrap  = w;
      if (upd) begin
        m_sum   = (m_sum + t > 65535) ? 65535 : m_sum + t;
        m_count = (m_count == 255) ? 255 : m_count + 1;
      end
      e.total = m_total; e.wrap = m_wrap; e.sum = m_sum; e.count = m_count;
      sb.push_back(e);
      exp_valid = 1;
    end
    @(posedge clk);
    #1;
    if (exp_valid == 1) begin
      chk("out_valid", int'(bus.out_valid), 1);
      if (sb.size() == 0) begin
        chk("scoreboard_nonempty", 0, 1);
      end else begin
        e = sb.pop_front();
        chk("time_total", int'(bus.time_total), e.total);
        chk("wrapped", int'(bus.wrapped), e.wrap);
        chk("total_sum", int'(bus.total_sum), e.sum);
        chk("car_count", int'(bus.car_count), e.count);
      end
    end else begin
      chk("out_valid_idle", int'(bus.out_valid), 0);
      chk("time_total_hold", int'(bus.time_total), m_total);
      chk("wrapped_hold", int'(bus.wrapped), m_wrap);
      chk("total_sum_hold", int'(bus.total_sum), m_sum);
      chk("car_count_hold", int'(bus.car_count), m_count);
    end
  endtask

  initial begin
    bus.in_valid = 1'b1;
    bus.time_in  = 8'd7;
    bus.time_out = 8'd9;

    // reset held two cycles with a valid pair present
    step(1, 1, 7, 9);
    step(1, 1, 7, 9);

    // directed vectors, back-to-back, with a hold cycle after the first
    step(1, 0, 1, 25);
    step(0, 0, 5, 9);
    step(1, 0, 3, 80);
    step(1, 0, 127, 255);
    step(1, 0, 1, 128);
    step(1, 0, 0, 84);
    step(1, 0, 24, 24);
    step(1, 0, 0, 0);
    chk("dir_car_count", int'(bus.car_count), 7);
    chk("dir_total_sum", int'(bus.total_sum), 440);
    step(0, 0, 0, 0);

    // rollover
    step(1, 0, 200, 10);
`ifdef TIME_CALC_SATURATE_EN
    chk("roll_total", int'(bus.time_total), 0);
    chk("roll_sum_unchanged", int'(bus.total_sum), 440);
`else
    chk("roll_total", int'(bus.time_total), 66);
    chk("roll_sum", int'(bus.total_sum), 506);
`endif
    chk("roll_wrapped", int'(bus.wrapped), 1);
    step(1, 0, 10, 200);
    chk("roll_clear", int'(bus.wrapped), 0);

    // mid-stream reset discards the pair presented with it
    step(1, 1, 10, 20);
    chk("rst_total", int'(bus.time_total), 0);
    chk("rst_count", int'(bus.car_count), 0);
    step(0, 0, 10, 20);

    // saturation: count clamps at 255, sum clamps at 65535
    for (int i = 0; i < 300; i++) begin
      step(1, 0, 0, 255);
      if (i == 254) begin
        chk("sat_count_255", int'(bus.car_count), 255);
        chk("sat_sum_255", int'(bus.total_sum), 65025);
      end
    end
    chk("sat_count_end", int'(bus.car_count), 255);
    chk("sat_sum_end", int'(bus.total_sum), 65535);
    step(0, 0, 0, 0);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
